// File: rtl/ext_ram_responder.sv
// ext_ram_responder: loads a program image into a small RAM, then serves CPU RAM reads/writes and I/O strobes.
module ext_ram_responder #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ram_addr,
  input  logic       ram_we,
  input  logic       ram_oe,
  input  logic       io_write,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic       load_start,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       load_done,
  output logic       cpu_rst_n,
  output logic [7:0] io_latch,
  output logic [7:0] io_count
);
  typedef enum logic [1:0] {LOAD, RELEASE, RUN} state_t;
  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [4:0] cnt;
  logic [7:0] rd_q;
  logic       io_prev;
  logic       last;
  assign bus_oe  = state == RUN && ram_oe && !ram_we;
  assign bus_out = rd_q;
  assign last    = cnt == 5'(DEPTH - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      cnt        <= '0;
      rd_q       <= '0;
      io_latch   <= '0;
      io_count   <= '0;
      io_prev    <= 1'b0;
      load_ready <= 1'b1;
      load_done  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // the previous sample follows io_write everywhere so a strobe held across RUN entry is not an edge
      io_prev <= io_write;
      case (state)
        LOAD: if (load_valid) begin
          mem[cnt] <= load_data;
          cnt      <= last ? '0 : cnt + 5'd1;
          if (last) begin
            state      <= RELEASE;
            load_ready <= 1'b0;
          end
        end
        RELEASE: begin
          state     <= RUN;
          cpu_rst_n <= 1'b1;
          load_done <= 1'b1;
        end
        default: begin
          if (ram_we) mem[ram_addr] <= bus_in;
          else if (ram_oe) rd_q <= mem[ram_addr];
          if (io_write && !io_prev) begin
            io_latch <= bus_in;
            io_count <= io_count + 8'd1;
          end
          if (load_start) begin
            state      <= LOAD;
            cnt        <= '0;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
            cpu_rst_n  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ext_ram_responder.sv
// tb_ext_ram_responder: random and directed stimulus checked against a phase/array reference model.
module tb_ext_ram_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ram_addr = '0;
  logic       ram_we = 1'b0, ram_oe = 1'b0, io_write = 1'b0;
  logic [7:0] bus_in = '0;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       load_start = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, load_done, cpu_rst_n;
  logic [7:0] io_latch, io_count;
  int         n_tests = 0, n_fail = 0;
  int         ph = 0, m_cnt = 0;
  logic [7:0] m_mem [32];
  logic [7:0] m_rd = '0, m_latch = '0, m_iocnt = '0;
  logic       m_prev = 1'b0;
  logic [7:0] c0, r0;
  always #5 clk = ~clk;
  ext_ram_responder dut (
    .clk(clk), .reset(reset), .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
    .io_write(io_write), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .load_done(load_done), .cpu_rst_n(cpu_rst_n),
    .io_latch(io_latch), .io_count(io_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // ph: 0 loading, 1 one-cycle release, 2 running
  task automatic model;
    if (reset) begin
      ph = 0; m_cnt = 0; m_rd = 0; m_latch = 0; m_iocnt = 0; m_prev = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      if (ph == 2) begin
        if (ram_we) m_mem[ram_addr] = bus_in;
        else if (ram_oe) m_rd = m_mem[ram_addr];
        if (io_write && !m_prev) begin
          m_latch = bus_in;
          m_iocnt = m_iocnt + 1;
        end
        if (load_start) begin
          ph = 0;
          m_cnt = 0;
        end
      end else if (ph == 1) ph = 2;
      else if (load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt = (m_cnt + 1) % 32;
        if (m_cnt == 0) ph = 1;
      end
      m_prev = io_write;
    end
  endtask
  task automatic cyc;
    #1 chk("bus_oe", bus_oe, ph == 2 && ram_oe && !ram_we);
    @(posedge clk);
    model();
    #1;
    chk("bus_out", bus_out, m_rd);
    chk("cpu_rst_n", cpu_rst_n, ph == 2);
    chk("load_ready", load_ready, ph == 0);
    chk("load_done", load_done, ph == 2);
    chk("io_latch", io_latch, m_latch);
    chk("io_count", io_count, m_iocnt);
  endtask
  task automatic idle;
    reset = 0; ram_we = 0; ram_oe = 0; io_write = 0; load_start = 0; load_valid = 0;
  endtask
  // streams one image with gaps and bus noise; seq selects bytes 0..31 instead of random data
  task automatic load_image(input bit seq);
    for (int k = 0; k < 400 && ph == 0; k++) begin
      load_valid = $urandom_range(0, 2) != 0;
      load_data  = seq ? 8'(m_cnt) : 8'($urandom);
      ram_we = 1'($urandom); ram_oe = 1'($urandom); io_write = 1'($urandom);
      load_start = 1'($urandom); ram_addr = 5'($urandom); bus_in = 8'($urandom);
      cyc();
    end
    chk("load_finished", load_ready, 0);
    idle();
    cyc();
    chk("run_entered", cpu_rst_n, 1);
  endtask
  task automatic sweep(input bit seq);
    for (int a = 0; a < 32; a++) begin
      ram_oe = 1; ram_addr = 5'(a);
      cyc();
      chk("sweep", bus_out, seq ? 8'(a) : m_mem[a]);
    end
    idle();
  endtask
  initial begin
    @(posedge clk);
    #1 cyc();
    cyc();
    chk("reset_ready", load_ready, 1);
    chk("reset_rst_n", cpu_rst_n, 0);
    idle();
    load_image(1);
    sweep(1);
    ram_oe = 1; ram_addr = 5;
    cyc();
    chk("read5", bus_out, 8'h05);
    idle(); ram_we = 1; ram_addr = 5; bus_in = 8'hA5;
    cyc();
    idle(); ram_oe = 1; ram_addr = 5;
    cyc();
    chk("raw5", bus_out, 8'hA5);
    r0 = m_rd;
    ram_we = 1; ram_oe = 1; ram_addr = 3; bus_in = 8'h77;
    cyc();
    chk("we_oe_hold", bus_out, r0);
    idle(); ram_oe = 1; ram_addr = 3;
    cyc();
    chk("read3", bus_out, 8'h77);
    idle();
    c0 = m_iocnt;
    io_write = 1; bus_in = 8'h3C;
    cyc();
    chk("io_first", io_latch, 8'h3C);
    io_write = 0;
    cyc();
    io_write = 1; bus_in = 8'h55;
    repeat (5) cyc();
    io_write = 0;
    cyc();
    chk("io_latch55", io_latch, 8'h55);
    chk("io_two", io_count, c0 + 8'd2);
    c0 = m_iocnt;
    for (int p = 0; p < 256; p++) begin
      io_write = 1; bus_in = 8'($urandom);
      cyc();
      io_write = 0;
      cyc();
    end
    chk("io_wrap", io_count, c0);
    for (int t = 0; t < 3000; t++) begin
      reset = $urandom_range(0, 399) == 0;
      load_start = $urandom_range(0, 149) == 0;
      load_valid = ph == 0 && $urandom_range(0, 3) != 0;
      load_data = 8'($urandom);
      ram_we = $urandom_range(0, 3) == 0; ram_oe = 1'($urandom); io_write = 1'($urandom);
      ram_addr = 5'($urandom); bus_in = 8'($urandom);
      cyc();
    end
    idle();
    for (int k = 0; k < 400 && ph != 2; k++) begin
      load_valid = 1; load_data = 8'($urandom);
      cyc();
    end
    idle(); load_start = 1;
    cyc();
    chk("restart_ready", load_ready, 1);
    idle();
    repeat (10) begin
      load_valid = 1; load_data = 8'($urandom);
      cyc();
    end
    idle(); reset = 1;
    cyc();
    idle();
    chk("mid_reset_done", load_done, 0);
    chk("mid_reset_count", io_count, 0);
    load_image(0);
    sweep(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
